// File: rtl/ram_mem_ctrl_pkg.sv
// Shared types and helpers for the RAM arbiter/sequencer and its store-merge unit.
package ram_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef enum logic {
    IDLE   = 1'b0,
    RMW_WR = 1'b1
  } state_e;

  // Number of bits needed to represent value (0 for value 0).
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/ram_mem_ctrl_store_merge.sv
// Replaces the addressed byte/halfword lane of an old RAM word with right-aligned store data.
module store_merge
  import ram_mem_ctrl_pkg::*;
(
  input  logic [31:0] old_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] merged_o
);

  always_comb begin
    merged_o = old_i;
    case (size_i)
      SZ_B:    merged_o[{addr_i, 3'b000} +: 8]     = wdata_i[7:0];
      SZ_H:    merged_o[{addr_i[1], 4'b0000} +: 16] = wdata_i[15:0];
      SZ_W:    merged_o = wdata_i;
      default: merged_o = old_i;
    endcase
  end

endmodule

// File: rtl/ram_mem_ctrl.sv
// Shares a single-port combinational-read RAM between instruction fetch and the LSU,
// with starvation-bounded LSU priority, access checking and read-modify-write sub-word stores.
module ram_mem_ctrl
  import ram_mem_ctrl_pkg::*;
#(
  parameter int RAM_DEPTH    = 1024,
  parameter int STARVE_LIMIT = 4,
  parameter int RAM_WIDTH    = 32,
  localparam int ADDR_W      = clogb2(RAM_DEPTH - 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 if_req,
  input  logic [31:0]          if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [RAM_WIDTH-1:0] if_rdata,
  output logic                 if_err,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [1:0]           lsu_size,
  input  logic [31:0]          lsu_addr,
  input  logic [RAM_WIDTH-1:0] lsu_wdata,
  output logic                 lsu_gnt,
  output logic                 lsu_rvalid,
  output logic [RAM_WIDTH-1:0] lsu_rdata,
  output logic                 lsu_err,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic [RAM_WIDTH-1:0] ram_din,
  output logic                 ram_we,
  input  logic [RAM_WIDTH-1:0] ram_dout
);

  localparam int STREAK_W                = clogb2(STARVE_LIMIT);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);
  localparam logic [31:0] BYTE_LIMIT     = 32'(RAM_DEPTH * 4);

  state_e                 state_q, state_d;
  logic [STREAK_W-1:0]    streak_q, streak_d;
  logic [ADDR_W-1:0]      rmw_addr_q, rmw_addr_d;
  logic [RAM_WIDTH-1:0]   rmw_data_q, rmw_data_d;
  logic                   if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic                   lsu_rvalid_q, lsu_rvalid_d, lsu_err_q, lsu_err_d;
  logic [RAM_WIDTH-1:0]   if_rdata_q, if_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic [RAM_WIDTH-1:0]   merged;
  logic                   lsu_bad, if_bad, starve;

  function automatic logic out_of_range(input logic [31:0] a);
    return a >= BYTE_LIMIT;
  endfunction

  assign lsu_bad = out_of_range(lsu_addr) || (lsu_size == 2'b11) ||
                   ((lsu_size == SZ_H) && lsu_addr[0]) ||
                   ((lsu_size == SZ_W) && (lsu_addr[1:0] != 2'b00));
  assign if_bad  = out_of_range(if_addr) || (if_addr[1:0] != 2'b00);
  assign starve  = if_req && (streak_q == STREAK_MAX);

  store_merge u_merge (
    .old_i    (ram_dout),
    .wdata_i  (lsu_wdata),
    .size_i   (lsu_size),
    .addr_i   (lsu_addr[1:0]),
    .merged_o (merged)
  );

  always_comb begin
    state_d      = state_q;
    streak_d     = streak_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_data_d   = rmw_data_q;
    if_rvalid_d  = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = '0;
    lsu_rvalid_d = 1'b0;
    lsu_err_d    = 1'b0;
    lsu_rdata_d  = '0;
    if_gnt       = 1'b0;
    lsu_gnt      = 1'b0;
    ram_addr     = lsu_addr[ADDR_W+1:2];
    ram_din      = lsu_wdata;
    ram_we       = 1'b0;

    case (state_q)
      IDLE: begin
        lsu_gnt = lsu_req && !starve;
        if_gnt  = if_req && !lsu_gnt;
        if (lsu_gnt) begin
          lsu_rvalid_d = 1'b1;
          lsu_err_d    = lsu_bad;
          if (!lsu_bad) begin
            if (!lsu_we) begin
              lsu_rdata_d = ram_dout;
            end else if (lsu_size == SZ_W) begin
              ram_we = 1'b1;
            end else begin
              // Sub-word store: hold the ack until the merged word is written back.
              lsu_rvalid_d = 1'b0;
              rmw_addr_d   = lsu_addr[ADDR_W+1:2];
              rmw_data_d   = merged;
              state_d      = RMW_WR;
            end
          end
        end else if (if_gnt) begin
          ram_addr    = if_addr[ADDR_W+1:2];
          if_rvalid_d = 1'b1;
          if_err_d    = if_bad;
          if_rdata_d  = if_bad ? '0 : ram_dout;
        end
        if (!if_req || if_gnt) begin
          streak_d = '0;
        end else if (lsu_gnt && (streak_q != STREAK_MAX)) begin
          streak_d = streak_q + 1'b1;
        end
      end
      RMW_WR: begin
        ram_addr     = rmw_addr_q;
        ram_din      = rmw_data_q;
        ram_we       = 1'b1;
        lsu_rvalid_d = 1'b1;
        state_d      = IDLE;
        if (!if_req) streak_d = '0;
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides the strobes asynchronously so an interrupted RMW never writes.
    if (!rst_n) begin
      if_gnt  = 1'b0;
      lsu_gnt = 1'b0;
      ram_we  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      streak_q     <= '0;
      rmw_addr_q   <= '0;
      rmw_data_q   <= '0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      lsu_rvalid_q <= 1'b0;
      lsu_err_q    <= 1'b0;
      lsu_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      streak_q     <= streak_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_data_q   <= rmw_data_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      lsu_rvalid_q <= lsu_rvalid_d;
      lsu_err_q    <= lsu_err_d;
      lsu_rdata_q  <= lsu_rdata_d;
    end
  end

  assign if_rvalid  = if_rvalid_q;
  assign if_err     = if_err_q;
  assign if_rdata   = if_rdata_q;
  assign lsu_rvalid = lsu_rvalid_q;
  assign lsu_err    = lsu_err_q;
  assign lsu_rdata  = lsu_rdata_q;

endmodule

// File: tb/tb_ram_mem_ctrl.sv
// Directed bench for ram_mem_ctrl with a behavioural combinational-read RAM.
module tb_ram_mem_ctrl;

  logic        clk, rst_n;
  logic        if_req, if_gnt, if_rvalid, if_err;
  logic [31:0] if_addr, if_rdata;
  logic        lsu_req, lsu_we, lsu_gnt, lsu_rvalid, lsu_err;
  logic [1:0]  lsu_size;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        ram_we;

  logic [31:0] mem [0:1023];
  logic        pre_we;
  logic [9:0]  pre_addr;
  logic [31:0] pre_data;

  int n_chk  = 0;
  int n_pass = 0;

  ram_mem_ctrl #(.RAM_DEPTH(1024), .STARVE_LIMIT(4), .RAM_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_we(ram_we), .ram_dout(ram_dout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_din;
    else if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign ram_dout = mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [9:0] a, input logic [31:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    cyc();
    pre_we   = 1'b0;
  endtask

  logic [31:0] err_addr [3] = '{32'h0000_1000, 32'h0000_0003, 32'h0000_0000};
  logic [1:0]  err_size [3] = '{2'b10, 2'b01, 2'b11};

  initial begin
    clk = 0; rst_n = 1; pre_we = 0; pre_addr = '0; pre_data = '0;
    if_req = 1; if_addr = 32'h10;
    lsu_req = 1; lsu_we = 1; lsu_size = 2'b10; lsu_addr = 0; lsu_wdata = 32'h1;
    #1 rst_n = 0;

    // reset with both requests asserted
    preload(10'd4, 32'hDEADBEEF);
    preload(10'd8, 32'h0BADF00D);
    preload(10'd2, 32'h11223344);
    preload(10'd1, 32'hCAFEF00D);
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_lsu_gnt", 32'(lsu_gnt), 0);
    chk("rst_ram_we", 32'(ram_we), 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    chk("rst_lsu_rvalid", 32'(lsu_rvalid), 0);
    chk("rst_errs", {30'b0, if_err, lsu_err}, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_lsu_rdata", lsu_rdata, 0);
    if_req = 0; lsu_req = 0; rst_n = 1;
    cyc();

    // IF-only fetch
    if_req = 1; if_addr = 32'h10;
    #1;
    chk("fetch_gnt", 32'(if_gnt), 1);
    chk("fetch_ram_addr", 32'(ram_addr), 4);
    cyc();
    if_req = 0;
    chk("fetch_rvalid", 32'(if_rvalid), 1);
    chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
    chk("fetch_err", 32'(if_err), 0);

    // contention: LSU loads vs fetches, 4:1 pattern
    lsu_we = 0; lsu_size = 2'b10; lsu_addr = 32'h20;
    if_req = 1; lsu_req = 1;
    for (int i = 0; i < 10; i++) begin
      logic el;
      el = (i % 5) != 4;
      #1;
      chk($sformatf("arb_lsu_gnt%0d", i), 32'(lsu_gnt), 32'(el));
      chk($sformatf("arb_if_gnt%0d", i), 32'(if_gnt), 32'(!el));
      cyc();
      chk($sformatf("arb_lsu_rv%0d", i), 32'(lsu_rvalid), 32'(el));
      chk($sformatf("arb_if_rv%0d", i), 32'(if_rvalid), 32'(!el));
      if (el) chk($sformatf("arb_lsu_data%0d", i), lsu_rdata, 32'h0BADF00D);
      else    chk($sformatf("arb_if_data%0d", i), if_rdata, 32'hDEADBEEF);
    end
    if_req = 0; lsu_req = 0;
    cyc();

    // byte store RMW with a competing fetch, then read-back
    lsu_we = 1; lsu_size = 2'b00; lsu_addr = 32'hA; lsu_wdata = 32'hFFFF_FFAB;
    lsu_req = 1; if_req = 1; if_addr = 32'h10;
    #1;
    chk("rmw_t_lsu_gnt", 32'(lsu_gnt), 1);
    chk("rmw_t_if_gnt", 32'(if_gnt), 0);
    chk("rmw_t_ram_we", 32'(ram_we), 0);
    cyc();
    lsu_req = 0;
    #1;
    chk("rmw_t1_if_gnt", 32'(if_gnt), 0);
    chk("rmw_t1_ram_we", 32'(ram_we), 1);
    chk("rmw_t1_ram_addr", 32'(ram_addr), 2);
    chk("rmw_t1_ram_din", ram_din, 32'h11AB3344);
    chk("rmw_t1_no_ack", 32'(lsu_rvalid), 0);
    cyc();
    chk("rmw_t2_ack", 32'(lsu_rvalid), 1);
    chk("rmw_t2_ack_data", lsu_rdata, 0);
    chk("rmw_t2_err", 32'(lsu_err), 0);
    chk("rmw_mem2", mem[2], 32'h11AB3344);
    lsu_req = 1; lsu_we = 0; lsu_size = 2'b10; lsu_addr = 32'h8;
    #1;
    chk("rb_lsu_gnt", 32'(lsu_gnt), 1);
    chk("rb_if_gnt", 32'(if_gnt), 0);
    cyc();
    lsu_req = 0;
    chk("rb_rvalid", 32'(lsu_rvalid), 1);
    chk("rb_rdata", lsu_rdata, 32'h11AB3344);
    #1;
    chk("rb_if_gnt_after", 32'(if_gnt), 1);
    cyc();
    if_req = 0;
    chk("rb_if_rvalid", 32'(if_rvalid), 1);
    chk("rb_if_rdata", if_rdata, 32'hDEADBEEF);

    // error accesses: out of range, misaligned half, illegal size
    lsu_we = 1; lsu_wdata = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      lsu_req = 1; lsu_addr = err_addr[i]; lsu_size = err_size[i];
      #1;
      chk($sformatf("err%0d_gnt", i), 32'(lsu_gnt), 1);
      chk($sformatf("err%0d_we", i), 32'(ram_we), 0);
      cyc();
      chk($sformatf("err%0d_rvalid", i), 32'(lsu_rvalid), 1);
      chk($sformatf("err%0d_err", i), 32'(lsu_err), 1);
      chk($sformatf("err%0d_rdata", i), lsu_rdata, 0);
    end
    lsu_req = 0;
    #1;
    chk("err_after_we", 32'(ram_we), 0);
    cyc();

    // reset during RMW_WR of a half store
    lsu_req = 1; lsu_we = 1; lsu_size = 2'b01; lsu_addr = 32'h4; lsu_wdata = 32'h0000_5A5A;
    #1;
    chk("rrst_gnt", 32'(lsu_gnt), 1);
    cyc();
    lsu_req = 0;
    chk("rrst_din", ram_din, 32'hCAFE5A5A);
    chk("rrst_we_pre", 32'(ram_we), 1);
    rst_n = 0;
    #1;
    chk("rrst_we_cut", 32'(ram_we), 0);
    cyc();
    cyc();
    chk("rrst_mem1", mem[1], 32'hCAFEF00D);
    chk("rrst_no_ack", 32'(lsu_rvalid), 0);
    rst_n = 1;
    #1;
    chk("rrst_outs", {26'b0, if_gnt, lsu_gnt, ram_we, if_rvalid, lsu_rvalid, if_err | lsu_err}, 0);
    chk("rrst_rdata", if_rdata | lsu_rdata, 0);
    cyc();
    chk("rrst_late_ack", 32'(lsu_rvalid), 0);
    lsu_req = 1; lsu_we = 0; lsu_size = 2'b10; lsu_addr = 32'h4;
    #1;
    chk("rrst_idle_gnt", 32'(lsu_gnt), 1);
    cyc();
    lsu_req = 0;
    chk("rrst_load_rv", 32'(lsu_rvalid), 1);
    chk("rrst_load_data", lsu_rdata, 32'hCAFEF00D);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/ram_mem_ctrl.md
Name:
ram_mem_ctrl

Overview:
Arbiter and sequencer that shares the single-port, 32-bit-wide, combinational-read RAM between instruction fetch (IF, read-only) and the load/store unit (LSU). The RAM has no byte enables, so this block performs byte and halfword stores as a read-modify-write (RMW). It also range-checks and alignment-checks every access and returns one registered response per grant.

Parameters:
RAM_DEPTH, 1024, number of 32-bit words; ADDR_W = clogb2(RAM_DEPTH-1) is the word-address width
STARVE_LIMIT, 4, consecutive LSU grants allowed while if_req is pending before IF is forced through
RAM_WIDTH, 32, data width; fixed at 32

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_gnt
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch accepted this cycle (combinational)
if_rvalid  out  1  fetch response valid; pulses 1 cycle
if_rdata  out  32  fetched word
if_err  out  1  qualifies if_rvalid: out-of-range or misaligned
lsu_req  in  1  LSU request; held until lsu_gnt
lsu_we  in  1  1 = store, 0 = load
lsu_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal
lsu_addr  in  32  LSU byte address
lsu_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
lsu_gnt  out  1  LSU accepted this cycle (combinational)
lsu_rvalid  out  1  LSU response (load data or store ack); pulses 1 cycle
lsu_rdata  out  32  aligned raw word; the LSU extracts and extends the lane
lsu_err  out  1  qualifies lsu_rvalid
ram_addr  out  ADDR_W  word address = byte_addr[ADDR_W+1:2]
ram_din  out  32  RAM write data
ram_we  out  1  RAM write strobe, sampled at posedge
ram_dout  in  32  combinational RAM read data (same cycle as ram_addr)

Behaviour:
- Reset (async, rst_n low): state IDLE, streak counter 0, all rvalid/err 0, rdata 0. While rst_n is low, if_gnt, lsu_gnt and ram_we are forced to 0. An RMW cut by reset is dropped: no write, no ack.
- FSM states: IDLE and RMW_WR. Grants are issued only in IDLE. In RMW_WR both gnt outputs are 0.
- Arbitration in IDLE: LSU has fixed priority. Exception: if the streak counter equals STARVE_LIMIT and if_req is high, IF wins.
- Streak counter: increments on each LSU grant while if_req=1. Clears on an IF grant or whenever if_req=0. Saturates at STARVE_LIMIT.
- Error check (in the grant cycle): error if byte_addr >= RAM_DEPTH*4, if lsu_size=11, if a half has addr[0]=1, or if a word has addr[1:0]!=0 (IF is always a word access). An error is granted normally: no RAM write, response is rvalid=1, err=1, rdata=0 in cycle T+1.
- Read (IF fetch or LSU load) granted at T: ram_addr is driven at T, ram_dout is registered, rvalid=1 with data at T+1.
- Word store granted at T: ram_we=1 and ram_din=wdata at T; ack (lsu_rvalid=1, lsu_rdata=0) at T+1.
- Byte/half store granted at T: read at T; merged word (ram_dout with the addressed lane(s) replaced by wdata) is registered along with the word address; state moves to RMW_WR. At T+1: ram_we=1 with the merged word, state returns to IDLE. Ack at T+2.
- Throughput: one grant per cycle in IDLE. Responses always return in grant order, at most one per requester per cycle.
- A new grant in the cycle an ack/rvalid is issued is allowed; a back-to-back read after an RMW sees the written data.
- Req is dropped without a gnt: nothing happens.

Decomposition:
- Package ram_mem_ctrl_pkg: size enum (SZ_B, SZ_H, SZ_W), state enum (IDLE, RMW_WR), clogb2 function.
- Sub-module store_merge (combinational): inputs old word, wdata, size, addr[1:0]; output merged word.

Test Plan:
- IF-only fetch at 0x0000_0010 with RAM[4]=0xDEADBEEF -> if_gnt at T, if_rvalid=1 and if_rdata=0xDEADBEEF at T+1, if_err=0.
- if_req and lsu_req held high together (LSU loads) for 10 cycles -> 4 LSU grants, 1 IF grant, repeating; no response lost.
- RAM[2]=0x11223344, LSU byte store 0xAB to 0x0000_000A -> RAM write at T+1 of 0x11AB3344, ack at T+2; IF held off during T+1; a following load from 0x8 returns 0x11AB3344.
- LSU word store to 0x0000_1000 (=RAM_DEPTH*4), a half store to 0x3, and a size=11 access -> each gets lsu_rvalid=1, lsu_err=1, rdata=0; ram_we never asserted.
- rst_n pulled low during RMW_WR of a half store to 0x4 -> ram_we stays 0, RAM[1] unchanged, no ack; after release all outputs are 0 and state is IDLE.
